// File: rtl/p1_pkg.sv
// Shared constants, FSM state type and signed-max helper for the pooling-1 write stage.
package p1_pkg;

    localparam int unsigned IMG_W     = 24;
    localparam int unsigned IMG_H     = 24;
    localparam int unsigned DW        = 16;
    localparam int unsigned AW        = 8;
    localparam int unsigned P1_PIXELS = (IMG_W / 2) * (IMG_H / 2);
    localparam int unsigned RB_DEPTH  = IMG_W / 2;
    localparam int unsigned RB_AW     = $clog2(RB_DEPTH);
    localparam int unsigned COL_W     = $clog2(IMG_W);
    localparam int unsigned ROW_W     = $clog2(IMG_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } p1_state_t;

    // Signed max; on a tie either operand is the same value.
    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/p1_row_buf.sv
// Half-row buffer holding the horizontal pair maxima of the even row of each window row pair.
module p1_row_buf
    import p1_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [RB_AW-1:0] waddr,
    input  logic [DW-1:0]    wdata,
    input  logic [RB_AW-1:0] raddr,
    output logic [DW-1:0]    rdata_c
);

    // Contents are always written on the even row before the odd row reads them.
    logic [DW-1:0] mem_q [RB_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/p1_pool_write.sv
// Pooling-1 stage: 2x2 stride-2 max pooling of the conv1 raster stream into P1 memory.
module p1_pool_write
    import p1_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    output logic          pix_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          done
);

    p1_state_t        state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [AW-1:0]    out_idx_q, out_idx_d;
    logic [DW-1:0]    hold_q, hold_d;
    logic             pix_ready_q, pix_ready_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic             done_q, done_d;

    logic             xfer_c;
    logic             col_end_c;
    logic             row_end_c;
    logic             rb_we_c;
    logic [DW-1:0]    pair_max_c;
    logic [DW-1:0]    rb_rdata_c;

    assign xfer_c     = pix_valid & pix_ready_q;
    assign col_end_c  = (col_q == COL_W'(IMG_W - 1));
    assign row_end_c  = (row_q == ROW_W'(IMG_H - 1));
    assign pair_max_c = smax(hold_q, pix_data);
    assign rb_we_c    = xfer_c & col_q[0] & ~row_q[0];

    p1_row_buf u_row_buf (
        .clk     (clk),
        .we      (rb_we_c),
        .waddr   (col_q[COL_W-1:1]),
        .wdata   (pair_max_c),
        .raddr   (col_q[COL_W-1:1]),
        .rdata_c (rb_rdata_c)
    );

    // Next-state, counters and output register inputs.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        out_idx_d = out_idx_q;
        hold_d    = hold_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    col_d     = '0;
                    row_d     = '0;
                    out_idx_d = '0;
                    wr_addr_d = '0;
                end
            end
            RUN: begin
                if (xfer_c) begin
                    if (!col_q[0]) begin
                        hold_d = pix_data;
                    end else if (row_q[0]) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = out_idx_q;
                        wr_data_d = smax(rb_rdata_c, pair_max_c);
                        out_idx_d = out_idx_q + AW'(1);
                    end

                    if (col_end_c) begin
                        col_d = '0;
                        if (row_end_c) begin
                            row_d   = '0;
                            state_d = LAST;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            LAST: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pix_ready_d = (state_d == RUN);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            out_idx_q   <= '0;
            hold_q      <= '0;
            pix_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_idx_q   <= out_idx_d;
            hold_q      <= hold_d;
            pix_ready_q <= pix_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
        end
    end

    assign pix_ready = pix_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_p1_pool_write.sv
// Bench for p1_pool_write: transfer-count reference model checked every cycle, plus literal pins.
module tb_p1_pool_write;
    import p1_pkg::*;

    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned OW   = IMG_W / 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] img      [NPIX];
    logic [DW-1:0] exp_pool [P1_PIXELS];
    logic [DW-1:0] p1mem    [P1_PIXELS];

    // Reference model state: image in progress, transfer count, expected outputs.
    bit            m_active = 1'b0;
    bit            m_wr     = 1'b0;
    bit            m_done   = 1'b0;
    bit            m_ready  = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_data   = '0;
    int            m_n      = 0;

    always #5 clk = ~clk;

    p1_pool_write dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected pooled image straight from the definition: max over each 2x2 window.
    function automatic void build_pool();
        int r, c, m, v;
        for (int k = 0; k < int'(P1_PIXELS); k++) begin
            r = k / int'(OW);
            c = k % int'(OW);
            m = int'($signed(img[(2 * r) * int'(IMG_W) + 2 * c]));
            v = int'($signed(img[(2 * r) * int'(IMG_W) + 2 * c + 1]));
            if (v > m) m = v;
            v = int'($signed(img[(2 * r + 1) * int'(IMG_W) + 2 * c]));
            if (v > m) m = v;
            v = int'($signed(img[(2 * r + 1) * int'(IMG_W) + 2 * c + 1]));
            if (v > m) m = v;
            exp_pool[k] = DW'(m);
        end
    endfunction

    // Per-cycle compare against the model, then advance the model by what the next edge does.
    always @(negedge clk) begin : mon
        int  r, c;
        bit  nxt_wr, nxt_done;
        if (reset) begin
            chk("rst_pix_ready", 32'(pix_ready), 32'd0);
            chk("rst_wr_en",     32'(wr_en),     32'd0);
            chk("rst_done",      32'(done),      32'd0);
            chk("rst_wr_addr",   32'(wr_addr),   32'd0);
            chk("rst_wr_data",   32'(wr_data),   32'd0);
            m_active = 1'b0;
            m_wr     = 1'b0;
            m_done   = 1'b0;
            m_ready  = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_n      = 0;
        end else begin
            chk("pix_ready", 32'(pix_ready), 32'(m_ready));
            chk("wr_en",     32'(wr_en),     32'(m_wr));
            chk("done",      32'(done),      32'(m_done));
            chk("wr_addr",   32'(wr_addr),   32'(m_addr));
            chk("wr_data",   32'(wr_data),   32'(m_data));
            if (wr_en && (wr_addr < AW'(P1_PIXELS))) p1mem[wr_addr] = wr_data;

            nxt_wr   = 1'b0;
            nxt_done = m_done || (m_wr && (m_addr == AW'(P1_PIXELS - 1)));
            if (start && !m_active && !(m_wr && (m_addr == AW'(P1_PIXELS - 1)))) begin
                m_active = 1'b1;
                m_n      = 0;
                nxt_done = 1'b0;
                m_addr   = '0;
            end else if (m_active && pix_valid) begin
                r = m_n / int'(IMG_W);
                c = m_n % int'(IMG_W);
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    nxt_wr = 1'b1;
                    m_addr = AW'((r / 2) * int'(OW) + c / 2);
                    m_data = exp_pool[(r / 2) * int'(OW) + c / 2];
                end
                m_n++;
                if (m_n == int'(NPIX)) m_active = 1'b0;
            end
            m_wr    = nxt_wr;
            m_done  = nxt_done;
            m_ready = m_active;
        end
    end

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Stream the first npix pixels of img, optionally with random gaps and stray start pulses.
    task automatic stream(input int npix, input bit gaps, input bit start_glitch);
        int g, guard;
        bit rdy;
        for (int i = 0; i < npix; i++) begin
            if (gaps) begin
                g = int'($urandom_range(0, 3));
                pix_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            pix_valid = 1'b1;
            pix_data  = img[i];
            if (start_glitch && (i == 100 || i == 400)) start = 1'b1;
            guard = 0;
            rdy   = 1'b0;
            while (!rdy && guard < 50) begin
                @(negedge clk);
                rdy = pix_ready;
                @(posedge clk); #1;
                start = 1'b0;
                guard++;
            end
            if (!rdy) begin
                chk("xfer_timeout", 32'd0, 32'd1);
                pix_valid = 1'b0;
                return;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int guard;
        guard = 0;
        while (guard < 20) begin
            @(negedge clk);
            if (done) break;
            guard++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic clear_mem();
        for (int k = 0; k < int'(P1_PIXELS); k++) p1mem[k] = 16'hDEAD;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < int'(NPIX); i++) img[i] = DW'(i);
        build_pool();
    endtask

    task automatic check_ramp(input string name);
        for (int k = 0; k < int'(P1_PIXELS); k++)
            chk(name, 32'(p1mem[k]), 32'(25 + 48 * (k / 12) + 2 * (k % 12)));
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // pix_valid while idle must do nothing
        pix_valid = 1'b1;
        pix_data  = 16'd123;
        repeat (5) begin @(posedge clk); #1; end
        pix_valid = 1'b0;
        chk("idle_no_write", 32'(wr_en), 32'd0);

        // ramp, continuous valid
        fill_ramp();
        clear_mem();
        do_start();
        stream(int'(NPIX), 1'b0, 1'b0);
        wait_done("ramp_done");
        chk("ramp_a0",   32'(p1mem[0]),   32'd25);
        chk("ramp_a11",  32'(p1mem[11]),  32'd47);
        chk("ramp_a12",  32'(p1mem[12]),  32'd73);
        chk("ramp_a143", 32'(p1mem[143]), 32'd575);
        check_ramp("ramp_mem");

        // pix_valid while done must do nothing
        pix_valid = 1'b1;
        pix_data  = 16'd999;
        repeat (5) begin @(posedge clk); #1; end
        pix_valid = 1'b0;
        chk("done_hold", 32'(done), 32'd1);

        // restart from DONE with a constant image
        for (int i = 0; i < int'(NPIX); i++) img[i] = DW'(7);
        build_pool();
        clear_mem();
        do_start();
        chk("done_drop", 32'(done), 32'd0);
        stream(int'(NPIX), 1'b0, 1'b0);
        wait_done("const_done");
        chk("const_a0",   32'(p1mem[0]),   32'd7);
        chk("const_a143", 32'(p1mem[143]), 32'd7);
        for (int k = 0; k < int'(P1_PIXELS); k++) chk("const_mem", 32'(p1mem[k]), 32'd7);

        // negatives: signed compare
        for (int i = 0; i < int'(NPIX); i++) img[i] = DW'(-5);
        img[IMG_W + 1] = DW'(-2);
        build_pool();
        clear_mem();
        do_start();
        stream(int'(NPIX), 1'b0, 1'b0);
        wait_done("neg_done");
        chk("neg_a0", 32'(p1mem[0]), 32'h0000_FFFE);
        for (int k = 1; k < int'(P1_PIXELS); k++) chk("neg_mem", 32'(p1mem[k]), 32'h0000_FFFB);

        // gapped valid with stray start pulses during RUN
        fill_ramp();
        clear_mem();
        do_start();
        stream(int'(NPIX), 1'b1, 1'b1);
        wait_done("gap_done");
        check_ramp("gap_mem");

        // reset mid-image, then a full image
        fill_ramp();
        do_start();
        stream(300, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        chk("midrst_wr_en",   32'(wr_en),   32'd0);
        chk("midrst_done",    32'(done),    32'd0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
        #1 reset = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        clear_mem();
        do_start();
        stream(int'(NPIX), 1'b0, 1'b0);
        wait_done("rst_img_done");
        check_ramp("rst_img_mem");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
